// File: rtl/temp_scan_ctrl.sv
// Four-channel temperature scan controller: sequences the active-low channel select,
// captures each settled reading, then averages the scan and flags over-limit channels.
module temp_scan_ctrl #(
  parameter int SETTLE = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_continuous,
  input  logic [9:0] i_hi_limit,
  input  logic [9:0] i_temp,
  output logic [3:0] o_select,
  output logic [9:0] o_temp0,
  output logic [9:0] o_temp1,
  output logic [9:0] o_temp2,
  output logic [9:0] o_temp3,
  output logic [9:0] o_avg,
  output logic [3:0] o_alarm,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(SETTLE - 1);

  state_t      r_state;
  logic [1:0]  r_ch;
  logic [7:0]  r_cnt;
  logic [3:0]  r_select;
  logic [9:0]  r_temp [4];
  logic [9:0]  r_avg;
  logic [3:0]  r_alarm;
  logic        r_busy;
  logic        r_done;
  logic        r_valid;

  logic [1:0]  w_next_ch;
  logic [11:0] w_sum;

  assign w_next_ch = r_ch + 2'd1;
  assign w_sum     = {2'b00, r_temp[0]} + {2'b00, r_temp[1]}
                   + {2'b00, r_temp[2]} + {2'b00, r_temp[3]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_ch     <= 2'd0;
      r_cnt    <= 8'd0;
      r_select <= 4'b1111;
      for (int i = 0; i < 4; i++) r_temp[i] <= 10'd0;
      r_avg    <= 10'd0;
      r_alarm  <= 4'b0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_SETTLE;
            r_ch     <= 2'd0;
            r_cnt    <= 8'd0;
            r_select <= 4'b1110;
            r_busy   <= 1'b1;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == LP_CNT_LAST) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_temp[r_ch]  <= i_temp;
          r_alarm[r_ch] <= (i_temp > i_hi_limit);
          if (r_ch != 2'd3) begin
            r_ch     <= w_next_ch;
            r_cnt    <= 8'd0;
            r_select <= ~(4'b0001 << w_next_ch);
            r_state  <= S_SETTLE;
          end else begin
            r_select <= 4'b1111;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          // Floor divide by four: drop the two LSBs of the 12-bit sum.
          r_avg   <= w_sum[11:2];
          r_done  <= 1'b1;
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (i_continuous) begin
            r_state  <= S_SETTLE;
            r_ch     <= 2'd0;
            r_cnt    <= 8'd0;
            r_select <= 4'b1110;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_select <= 4'b1111;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_select = r_select;
  assign o_temp0  = r_temp[0];
  assign o_temp1  = r_temp[1];
  assign o_temp2  = r_temp[2];
  assign o_temp3  = r_temp[3];
  assign o_avg    = r_avg;
  assign o_alarm  = r_alarm;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_valid  = r_valid;

endmodule

// File: doc/temp_scan_ctrl.md
# temp_scan_ctrl

Scan controller for the four-channel temperature averaging datapath. It drives the shared `temp` bus's active-low channel select, waits a programmable settle time per channel and captures each reading. After all four channels are captured it computes their average and flags over-limit channels. It sits between the sensor mux and the BCD display path: `avg` or any `tempN` feeds the display decoder directly.

## Interface
- `SETTLE`, default 4: cycles `select` is held on a channel before capture; legal range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one scan; sampled only in IDLE.
- `continuous`  in  1  when 1 at end of scan, the next scan starts immediately.
- `hi_limit`  in  10  alarm threshold, unsigned.
- `temp`  in  10  shared sensor reading for the currently selected channel, unsigned.
- `select`  out  4  one-hot active-low channel select: ch0=1110, ch1=1101, ch2=1011, ch3=0111, idle=1111.
- `temp0`..`temp3`  out  10 each  last captured reading per channel.
- `avg`  out  10  floor((temp0+temp1+temp2+temp3)/4) of the last completed scan.
- `alarm`  out  4  bit n = last captured tempN > hi_limit.
- `busy`  out  1  scan in progress (state != IDLE).
- `done`  out  1  one-cycle pulse; `avg` is valid and new in this cycle.
- `valid`  out  1  sticky; 1 once any scan has completed since reset.

## Operation
- Reset, asynchronous: state=IDLE, `select`=1111, `temp0`..`temp3`=0, `avg`=0, `alarm`=0, `busy`=0, `done`=0, `valid`=0, `ch`=0, settle counter=0.
- States: IDLE, SETTLE, CAPTURE, CALC, DONE.
- IDLE: `select`=1111. `start`=1 → SETTLE, `ch`=0, counter=0.
- SETTLE: `select` drives channel `ch`. The counter increments each cycle. At counter=SETTLE-1 → CAPTURE.
- CAPTURE: `select` still drives `ch`. At the edge:
  - `temp` is loaded into `temp[ch]`.
  - `alarm[ch]` is loaded with (`temp` > `hi_limit`).
  - If `ch`<3: `ch`+1, counter=0, → SETTLE.
  - Otherwise → CALC.
- CALC: `select`=1111. The 12-bit sum of `temp0`..`temp3` is computed zero-extended with no overflow; bits [11:2] are registered into `avg`. → DONE.
- DONE: `done`=1, `valid`←1, `select`=1111.
  - `continuous`=1 → SETTLE with `ch`=0.
  - Otherwise → IDLE.
- `start` is ignored outside IDLE; there is no queueing.
- Deasserting `continuous` mid-scan does not abort. The current scan completes, then the block returns to IDLE.
- Channel registers and `alarm` bits update per channel during a scan. Unscanned channels keep prior values until captured.
- `hi_limit` is sampled at each capture edge, not latched at `start`.
- `avg` changes only on the CALC→DONE edge.
- Reset mid-scan: immediate return to the reset values above; a partial scan is discarded.

## Timing
- `start` is sampled at edge E0. `select`=1110 is driven from E0 to E(SETTLE+1).
- Each channel holds `select` for SETTLE+1 cycles.
- Capture edges: ch0 at E(SETTLE+1), ch1 at E(2·(SETTLE+1)), ch2 at E(3·(SETTLE+1)), ch3 at E(4·(SETTLE+1)).
- `avg` is registered and `done`=1 from E(4·SETTLE+5) for exactly one cycle.
- With SETTLE=4: captures at E5, E10, E15, E20; `done` from E21.
- Continuous mode: `select`=1110 again from E(4·SETTLE+6). The DONE cycle is the only gap between scans (scan period 4·SETTLE+6).
- `busy` rises at E0 and falls at E(4·SETTLE+6) in single mode.
- `start` held high through DONE in single mode retriggers a scan; the next `start` sample is at E(4·SETTLE+6)+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → all outputs take their reset values immediately, `select`=1111, with no clock needed.
- Single scan, SETTLE=4, `temp` modelled as a mux of 100/200/300/400 keyed on `select` → `select` sequence 1110,1101,1011,0111 for 5 cycles each; `temp0..3`=100,200,300,400; `avg`=250; `done` pulse at E21 only; `busy` low at E22; `valid`=1.
- Arithmetic: inputs 1,1,1,2 → `avg`=1 (floor). Inputs all 1023 → `avg`=1023 (no overflow). `hi_limit`=500 with inputs 100,600,500,1023 → `alarm`=1010.
- Continuous: `continuous`=1, `start` pulse → `done` at E21, E43, E65 with `select`=1110 at E22. Drop `continuous` at E30 → `done` at E43, then IDLE with `select`=1111.
- `start` pulses at E3 and E21 during a scan → ignored; exactly one `done`. Mux values changed to 10,20,30,40 for a second run → `avg`=25.
- Reset at E12 mid-scan, then a fresh `start` → `temp0..3`=0 after reset, and the new scan runs the full 21-cycle sequence from ch0.
